hand_bank: RTL and testbench

HAND_BANK -- requirements
Module: hand_bank

---
 rtl/hand_bank.sv | 156 +++++++++++++++
 tb/tb_hand_bank.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hand_bank.sv
// hand_bank: banked storage for several card hands. Each hand has a
// running baccarat score and full/natural flags, and each hand can be cleared.
module hand_bank #(
  parameter int NUM_HANDS = 2,
  parameter int MAX_CARDS = 3,
  parameter int HW        = $clog2(NUM_HANDS)
) (
  input  logic                                     slow_clock,
  input  logic                                     resetb,
  input  logic                                     deal_valid,
  input  logic [HW-1:0]                            deal_hand,
  input  logic [3:0]                               deal_card,
  output logic                                     deal_ready,
  input  logic                                     clear_valid,
  input  logic [HW-1:0]                            clear_hand,
  output logic [NUM_HANDS*MAX_CARDS*4-1:0]         cards_flat,
  output logic [NUM_HANDS*$clog2(MAX_CARDS+1)-1:0] count_flat,
  output logic [NUM_HANDS*4-1:0]                   score_flat,
  output logic [NUM_HANDS-1:0]                     full,
  output logic [NUM_HANDS-1:0]                     natural,
  output logic                                     deal_err
);

  localparam int CW = $clog2(MAX_CARDS + 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] UPDATE = 1'b1;

  logic [0:0]    state;
  logic [HW-1:0] upd_hand;
  logic [3:0]    cards [NUM_HANDS][MAX_CARDS];
  logic [CW-1:0] count [NUM_HANDS];
  logic [3:0]    score [NUM_HANDS];

  logic          hand_ok;
  logic          card_ok;
  logic          deal_ok;
  logic [CW-1:0] tgt_count;
  logic [CW-1:0] upd_count;
  logic [4:0]    calc_score;

  // A card is only taken while idle. A pending clear has priority over a deal,
  // and no card is taken while reset is applied.
  assign deal_ready = (state == IDLE) && !clear_valid && !resetb;

  // Check the offered card. Card code 1-13 is valid, the hand index must be in
  // range, and the target hand must have a free slot.
  always_comb begin
    hand_ok   = 1'b0;
    tgt_count = '0;
    for (int h = 0; h < NUM_HANDS; h++) begin
      if (deal_hand == HW'(h)) begin
        hand_ok   = 1'b1;
        tgt_count = count[h];
      end
    end
    card_ok = (deal_card >= 4'd1) && (deal_card <= 4'd13);
    deal_ok = hand_ok && card_ok && (tgt_count != CW'(MAX_CARDS));
  end

  // Add the values of the hand being updated into a sum kept modulo 10.
  // Tens and face cards, and empty slots, add nothing.
  always_comb begin
    calc_score = '0;
    upd_count  = '0;
    for (int h = 0; h < NUM_HANDS; h++) begin
      if (upd_hand == HW'(h)) begin
        upd_count = count[h];
        for (int s = 0; s < MAX_CARDS; s++) begin
          if ((cards[h][s] >= 4'd1) && (cards[h][s] <= 4'd9)) begin
            calc_score = calc_score + {1'b0, cards[h][s]};
            if (calc_score >= 5'd10) begin
              calc_score = calc_score - 5'd10;
            end
          end
        end
      end
    end
  end

  // FSM and storage. IDLE stores accepted cards or clears a hand.
  // UPDATE registers the score and flags for the hand that just took a card.
  always_ff @(posedge slow_clock) begin
    if (resetb) begin
      state    <= IDLE;
      upd_hand <= '0;
      deal_err <= 1'b0;
      full     <= '0;
      natural  <= '0;
      for (int h = 0; h < NUM_HANDS; h++) begin
        count[h] <= '0;
        score[h] <= '0;
        for (int s = 0; s < MAX_CARDS; s++) begin
          cards[h][s] <= '0;
        end
      end
    end else begin
      deal_err <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_valid) begin
            for (int h = 0; h < NUM_HANDS; h++) begin
              if (clear_hand == HW'(h)) begin
                count[h]   <= '0;
                score[h]   <= '0;
                full[h]    <= 1'b0;
                natural[h] <= 1'b0;
                for (int s = 0; s < MAX_CARDS; s++) begin
                  cards[h][s] <= '0;
                end
              end
            end
          end else if (deal_valid) begin
            if (deal_ok) begin
              for (int h = 0; h < NUM_HANDS; h++) begin
                if (deal_hand == HW'(h)) begin
                  for (int s = 0; s < MAX_CARDS; s++) begin
                    if (count[h] == CW'(s)) begin
                      cards[h][s] <= deal_card;
                    end
                  end
                  count[h] <= count[h] + CW'(1);
                end
              end
              upd_hand <= deal_hand;
              state    <= UPDATE;
            end else begin
              deal_err <= 1'b1;
            end
          end
        end
        UPDATE: begin
          for (int h = 0; h < NUM_HANDS; h++) begin
            if (upd_hand == HW'(h)) begin
              score[h]   <= calc_score[3:0];
              full[h]    <= (upd_count == CW'(MAX_CARDS));
              natural[h] <= (upd_count == CW'(2)) && (calc_score >= 5'd8);
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  genvar gh, gs;
  for (gh = 0; gh < NUM_HANDS; gh++) begin : g_hand
    assign count_flat[gh*CW +: CW] = count[gh];
    assign score_flat[gh*4 +: 4]   = score[gh];
    for (gs = 0; gs < MAX_CARDS; gs++) begin : g_slot
      assign cards_flat[(gh*MAX_CARDS+gs)*4 +: 4] = cards[gh][gs];
    end
  end

endmodule

// File: tb/tb_hand_bank.sv
// tb_hand_bank: directed scoreboard bench for hand_bank. Instance A has
// 3 hands of 3 slots and instance B has 4 hands of 5 slots.
module tb_hand_bank;

  logic        slow_clock = 1'b0;
  logic        resetb;
  logic        a_dv;
  logic        b_dv;
  logic        clear_valid;
  logic [1:0]  deal_hand;
  logic [1:0]  clear_hand;
  logic [3:0]  deal_card;

  logic        a_ready, a_err;
  logic [35:0] a_cards;
  logic [5:0]  a_count;
  logic [11:0] a_score;
  logic [2:0]  a_full, a_nat;

  logic        b_ready, b_err;
  logic [79:0] b_cards;
  logic [11:0] b_count;
  logic [15:0] b_score;
  logic [3:0]  b_full, b_nat;

  int total  = 0;
  int passed = 0;

  typedef struct {
    string tag;
    int    hand;
    int    err;
    int    count;
    int    score;
    int    full;
    int    nat;
  } exp_t;
  exp_t sb[$];

  int m_cards [2][4][5];
  int m_count [2][4];
  int nh [2] = '{3, 4};
  int mc [2] = '{3, 5};

  always #5 slow_clock = ~slow_clock;

  hand_bank #(.NUM_HANDS(3), .MAX_CARDS(3)) dut_a (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .deal_valid (a_dv),
    .deal_hand  (deal_hand),
    .deal_card  (deal_card),
    .deal_ready (a_ready),
    .clear_valid(clear_valid),
    .clear_hand (clear_hand),
    .cards_flat (a_cards),
    .count_flat (a_count),
    .score_flat (a_score),
    .full       (a_full),
    .natural    (a_nat),
    .deal_err   (a_err)
  );

  hand_bank #(.NUM_HANDS(4), .MAX_CARDS(5)) dut_b (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .deal_valid (b_dv),
    .deal_hand  (deal_hand),
    .deal_card  (deal_card),
    .deal_ready (b_ready),
    .clear_valid(clear_valid),
    .clear_hand (clear_hand),
    .cards_flat (b_cards),
    .count_flat (b_count),
    .score_flat (b_score),
    .full       (b_full),
    .natural    (b_nat),
    .deal_err   (b_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [31:0] d_count(int w, int h);
    if (w == 0) return 32'(a_count[h*2 +: 2]);
    return 32'(b_count[h*3 +: 3]);
  endfunction

  function automatic logic [31:0] d_score(int w, int h);
    if (w == 0) return 32'(a_score[h*4 +: 4]);
    return 32'(b_score[h*4 +: 4]);
  endfunction

  function automatic logic [31:0] d_card(int w, int h, int s);
    if (w == 0) return 32'(a_cards[(h*3+s)*4 +: 4]);
    return 32'(b_cards[(h*5+s)*4 +: 4]);
  endfunction

  function automatic logic [31:0] d_full(int w, int h);
    if (w == 0) return 32'(a_full[h]);
    return 32'(b_full[h]);
  endfunction

  function automatic logic [31:0] d_nat(int w, int h);
    if (w == 0) return 32'(a_nat[h]);
    return 32'(b_nat[h]);
  endfunction

  function automatic logic [31:0] d_ready(int w);
    if (w == 0) return 32'(a_ready);
    return 32'(b_ready);
  endfunction

  function automatic logic [31:0] d_err(int w);
    if (w == 0) return 32'(a_err);
    return 32'(b_err);
  endfunction

  function automatic int card_val(int c);
    if (c >= 1 && c <= 9) return c;
    return 0;
  endfunction

  function automatic int m_score(int w, int h);
    int sum = 0;
    for (int i = 0; i < 5; i++) sum += card_val(m_cards[w][h][i]);
    return sum % 10;
  endfunction

  function automatic int m_full(int w, int h);
    return (m_count[w][h] == mc[w]) ? 1 : 0;
  endfunction

  function automatic int m_nat(int w, int h);
    return (m_count[w][h] == 2 && m_score(w, h) >= 8) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++)
      for (int h = 0; h < 4; h++) begin
        m_count[w][h] = 0;
        for (int s = 0; s < 5; s++) m_cards[w][h][s] = 0;
      end
  endtask

  task automatic model_clear(input int w, input int h);
    m_count[w][h] = 0;
    for (int s = 0; s < 5; s++) m_cards[w][h][s] = 0;
  endtask

  task automatic check_hand(input int w, input int h, input string tag);
    check($sformatf("%s_h%0d_count", tag, h), d_count(w, h), m_count[w][h]);
    check($sformatf("%s_h%0d_score", tag, h), d_score(w, h), m_score(w, h));
    check($sformatf("%s_h%0d_full", tag, h),  d_full(w, h),  m_full(w, h));
    check($sformatf("%s_h%0d_nat", tag, h),   d_nat(w, h),   m_nat(w, h));
    for (int s = 0; s < mc[w]; s++)
      check($sformatf("%s_h%0d_s%0d", tag, h, s), d_card(w, h, s), m_cards[w][h][s]);
  endtask

  // Offer one card, predict the result into the scoreboard, and compare the
  // DUT outputs as they appear: the error flag one edge after the accept and
  // the score and flags one edge after that.
  task automatic deal(input int w, input int h, input int card, input string tag);
    exp_t e;
    int   n;
    bit   ok;
    deal_hand = 2'(h);
    deal_card = 4'(card);
    if (w == 0) a_dv = 1'b1; else b_dv = 1'b1;
    n = 0;
    while (d_ready(w) !== 1 && n < 50) begin
      @(negedge slow_clock);
      n++;
    end
    if (n >= 50) check({tag, "_ready_timeout"}, d_ready(w), 1);
    ok = (card >= 1) && (card <= 13) && (h < nh[w]) && (m_count[w][h] < mc[w]);
    if (ok) begin
      m_cards[w][h][m_count[w][h]] = card;
      m_count[w][h]++;
    end
    e.tag   = tag;
    e.hand  = h;
    e.err   = ok ? 0 : 1;
    e.count = (h < nh[w]) ? m_count[w][h] : 0;
    e.score = (h < nh[w]) ? m_score(w, h) : 0;
    e.full  = (h < nh[w]) ? m_full(w, h) : 0;
    e.nat   = (h < nh[w]) ? m_nat(w, h) : 0;
    sb.push_back(e);
    @(negedge slow_clock);
    a_dv = 1'b0;
    b_dv = 1'b0;
    e = sb.pop_front();
    check({e.tag, "_err"}, d_err(w), e.err);
    check({e.tag, "_ready_busy"}, d_ready(w), e.err);
    @(negedge slow_clock);
    check({e.tag, "_err_gone"}, d_err(w), 0);
    check({e.tag, "_ready_back"}, d_ready(w), 1);
    if (e.hand < nh[w]) begin
      check({e.tag, "_count"}, d_count(w, e.hand), e.count);
      check({e.tag, "_score"}, d_score(w, e.hand), e.score);
      check({e.tag, "_full"},  d_full(w, e.hand),  e.full);
      check({e.tag, "_nat"},   d_nat(w, e.hand),   e.nat);
      for (int s = 0; s < mc[w]; s++)
        check($sformatf("%s_s%0d", e.tag, s), d_card(w, e.hand, s), m_cards[w][e.hand][s]);
    end
    if (e.err != 0) begin
      for (int k = 0; k < nh[w]; k++)
        check($sformatf("%s_keep_h%0d", e.tag, k), d_count(w, k), m_count[w][k]);
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Linear sequence of directed steps
  initial begin
    resetb      = 1'b1;
    a_dv        = 1'b0;
    b_dv        = 1'b0;
    clear_valid = 1'b0;
    clear_hand  = 2'd0;
    deal_hand   = 2'd0;
    deal_card   = 4'd0;
    model_reset();

    $display("[TB] reset");
    repeat (2) @(negedge slow_clock);
    check("rst_ready_a", d_ready(0), 0);
    check("rst_ready_b", d_ready(1), 0);
    resetb = 1'b0;
    #1;
    check("post_rst_ready_a", d_ready(0), 1);
    check("post_rst_ready_b", d_ready(1), 1);
    check("post_rst_err_a", d_err(0), 0);
    for (int h = 0; h < 3; h++) check_hand(0, h, "rst_a");
    for (int h = 0; h < 4; h++) check_hand(1, h, "rst_b");

    $display("[TB] basic deals");
    deal(0, 0, 7,  "h0_c7");
    deal(0, 0, 12, "h0_c12");
    deal(0, 1, 4,  "h1_c4");
    deal(0, 1, 5,  "h1_c5");
    deal(0, 1, 13, "h1_c13");
    deal(0, 1, 2,  "h1_overfull");

    $display("[TB] rejected cards");
    deal(0, 2, 0,  "card_zero");
    deal(0, 2, 15, "card_fifteen");
    deal(0, 3, 5,  "hand_range");

    $display("[TB] clear beats deal");
    clear_valid = 1'b1;
    clear_hand  = 2'd0;
    deal_hand   = 2'd0;
    deal_card   = 4'd3;
    a_dv        = 1'b1;
    #1;
    check("clr_deal_ready", d_ready(0), 0);
    @(negedge slow_clock);
    clear_valid = 1'b0;
    model_clear(0, 0);
    check_hand(0, 0, "clr");
    check_hand(0, 1, "clr_other");
    #1;
    check("clr_ready_after", d_ready(0), 1);
    @(negedge slow_clock);
    a_dv = 1'b0;
    m_cards[0][0][0] = 3;
    m_count[0][0]    = 1;
    check("clr_then_deal_busy", d_ready(0), 0);
    @(negedge slow_clock);
    check_hand(0, 0, "clr_then_deal");

    $display("[TB] clear held off during update");
    deal_hand = 2'd2;
    deal_card = 4'd6;
    a_dv      = 1'b1;
    @(negedge slow_clock);
    a_dv        = 1'b0;
    clear_valid = 1'b1;
    clear_hand  = 2'd1;
    m_cards[0][2][0] = 6;
    m_count[0][2]    = 1;
    @(negedge slow_clock);
    check_hand(0, 1, "holdoff");
    check_hand(0, 2, "holdoff");
    check("holdoff_ready", d_ready(0), 0);
    @(negedge slow_clock);
    clear_valid = 1'b0;
    model_clear(0, 1);
    check_hand(0, 1, "held_clr");
    check_hand(0, 0, "held_clr_other");

    $display("[TB] reset during update");
    deal_hand = 2'd1;
    deal_card = 4'd9;
    a_dv      = 1'b1;
    @(negedge slow_clock);
    a_dv = 1'b0;
    check("mid_upd_score", d_score(0, 1), 0);
    check("mid_upd_count", d_count(0, 1), 1);
    resetb = 1'b1;
    #1;
    check("mid_rst_ready", d_ready(0), 0);
    @(negedge slow_clock);
    model_reset();
    for (int h = 0; h < 3; h++) check_hand(0, h, "mid_rst");
    check("mid_rst_err", d_err(0), 0);
    check("mid_rst_ready_hold", d_ready(0), 0);
    resetb = 1'b0;
    #1;
    check("mid_rst_ready_rel", d_ready(0), 1);

    $display("[TB] fill sweep 3x3");
    for (int h = 0; h < 3; h++) begin
      deal(0, h, 13, $sformatf("fa_h%0d_k", h));
      for (int k = 1; k < 3; k++) deal(0, h, 1, $sformatf("fa_h%0d_a%0d", h, k));
      check($sformatf("fa_h%0d_aces", h), d_score(0, h), 2);
      check($sformatf("fa_h%0d_isfull", h), d_full(0, h), 1);
    end
    deal(0, 0, 1, "fa_extra");

    $display("[TB] fill sweep 4x5");
    for (int h = 0; h < 4; h++) begin
      deal(1, h, 13, $sformatf("fb_h%0d_k", h));
      for (int k = 1; k < 5; k++) deal(1, h, 1, $sformatf("fb_h%0d_a%0d", h, k));
      check($sformatf("fb_h%0d_aces", h), d_score(1, h), 4);
      check($sformatf("fb_h%0d_isfull", h), d_full(1, h), 1);
    end
    deal(1, 2, 1, "fb_extra");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
